// File: rtl/mmio_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_responder
//  Purpose  : I/O-space responder for the core: UART TX/RX and cycle counter.
//             Optional loopback of TX into RX under macro IO_LOOPBACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mmio_uart_responder #(
   parameter int CPU_CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE      = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  we,
   input  logic        re,
   output logic [31:0] rdata,
   input  logic        FPGA_SERIAL_RX,
   output logic        FPGA_SERIAL_TX
);

   localparam int c_CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
   localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);

   localparam logic [7:0] c_OFF_STATUS = 8'h00;
   localparam logic [7:0] c_OFF_RXDATA = 8'h04;
   localparam logic [7:0] c_OFF_TXDATA = 8'h08;
   localparam logic [7:0] c_OFF_CYCLE  = 8'h10;
   localparam logic [7:0] c_OFF_CCLEAR = 8'h18;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        cycle_q, cycle_d;
   tx_state_t          tx_state_q, tx_state_d;
   logic [c_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]         tx_bit_q, tx_bit_d;
   logic [7:0]         tx_shift_q, tx_shift_d;
   logic               tx_line_q, tx_line_d;
   logic [1:0]         rx_sync_q, rx_sync_d;
   rx_state_t          rx_state_q, rx_state_d;
   logic [c_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]         rx_bit_q, rx_bit_d;
   logic [7:0]         rx_shift_q, rx_shift_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               rx_overrun_q, rx_overrun_d;

   logic               w_rx_done;
   logic               w_rx_bit;
   logic               w_status_b3;
   logic [7:0]         w_off;
   logic               w_rd, w_wr;
   logic               w_rd_rxdata, w_tx_accept, w_cnt_clear, w_tx_ready;
   logic [31:0]        w_status;
   logic               w_unused;

   assign w_off       = addr[7:0];
   assign w_rd        = addr[31] & re;
   assign w_wr        = addr[31] & (we != 4'b0000);
   assign w_tx_ready  = (tx_state_q == TX_IDLE);
   assign w_rd_rxdata = w_rd & (w_off == c_OFF_RXDATA);
   assign w_tx_accept = w_wr & (w_off == c_OFF_TXDATA) & we[0] & w_tx_ready;
   assign w_cnt_clear = w_wr & (w_off == c_OFF_CCLEAR);
   assign w_status    = {28'h0, w_status_b3, rx_overrun_q, rx_valid_q, w_tx_ready};
   assign w_unused    = ^{addr[30:8], wdata[31:8]};
   assign rx_sync_d   = {rx_sync_q[0], FPGA_SERIAL_RX};

`ifdef IO_LOOPBACK_EN
   logic loop_en_q, loop_en_d;

   always_comb begin
      loop_en_d = loop_en_q;
      if (w_wr && (w_off == c_OFF_STATUS) && we[0]) begin
         loop_en_d = wdata[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) loop_en_q <= 1'b0;
      else     loop_en_q <= loop_en_d;
   end

   // TX is already synchronous to clk, so it bypasses the synchroniser.
   assign w_rx_bit    = loop_en_q ? tx_line_q : rx_sync_q[1];
   assign w_status_b3 = loop_en_q;
`else
   assign w_rx_bit    = rx_sync_q[1];
   assign w_status_b3 = 1'b0;
`endif

   always_comb begin
      rdata_d      = rdata_q;
      cycle_d      = cycle_q + 32'd1;
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_bit_d     = tx_bit_q;
      tx_shift_d   = tx_shift_q;
      tx_line_d    = tx_line_q;
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = rx_overrun_q;
      w_rx_done    = 1'b0;

      if (w_rd) begin
         case (w_off)
            c_OFF_STATUS: rdata_d = w_status;
            c_OFF_RXDATA: rdata_d = {24'h0, rx_data_q};
            c_OFF_CYCLE:  rdata_d = cycle_q;
            default:      rdata_d = 32'h0;
         endcase
      end

      if (w_cnt_clear) cycle_d = 32'h0;

      case (tx_state_q)
         TX_IDLE: begin
            if (w_tx_accept) begin
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_shift_d = wdata[7:0];
               tx_line_d  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == c_BIT_LAST) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_line_d  = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == c_BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_line_d  = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == c_BIT_LAST) tx_state_d = TX_IDLE;
            else                        tx_cnt_d   = tx_cnt_q + 1'b1;
         end
         default: tx_state_d = TX_IDLE;
      endcase

      case (rx_state_q)
         RX_IDLE: begin
            if (!w_rx_bit) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Half-bit resample rejects short low glitches on the line.
            if (rx_cnt_q == c_HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = 3'd0;
               rx_state_d = w_rx_bit ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == c_BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {w_rx_bit, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == c_BIT_LAST) begin
               rx_state_d = RX_IDLE;
               w_rx_done  = w_rx_bit;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      if (w_rd_rxdata) begin
         rx_valid_d   = 1'b0;
         rx_overrun_d = 1'b0;
      end
      // A byte landing during the data read is not an overrun: the reader got the old one.
      if (w_rx_done) begin
         rx_data_d    = rx_shift_q;
         rx_overrun_d = rx_overrun_d | (rx_valid_q & ~w_rd_rxdata);
         rx_valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q      <= 32'h0;
         cycle_q      <= 32'h0;
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= 3'd0;
         tx_shift_q   <= 8'h0;
         tx_line_q    <= 1'b1;
         rx_sync_q    <= 2'b11;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= 3'd0;
         rx_shift_q   <= 8'h0;
         rx_data_q    <= 8'h0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rdata_q      <= rdata_d;
         cycle_q      <= cycle_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_line_q    <= tx_line_d;
         rx_sync_q    <= rx_sync_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign rdata          = rdata_q;
   assign FPGA_SERIAL_TX = tx_line_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_uart_responder
//  Purpose  : Self-checking bench for mmio_uart_responder (CLKS_PER_BIT = 10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_uart_responder;

   localparam int CPB = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  we;
   logic        re;
   logic        rx, tx;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      logic        r;
      logic [31:0] exp;
   } vec_t;

   always #5 clk = ~clk;

   mmio_uart_responder #(
      .CPU_CLOCK_FREQ(100),
      .BAUD_RATE     (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .wdata         (wdata),
      .we            (we),
      .re            (re),
      .rdata         (rdata),
      .FPGA_SERIAL_RX(rx),
      .FPGA_SERIAL_TX(tx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; drives one bus cycle and returns at the next negedge.
   task automatic bus_cycle(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                            input logic r);
      addr = a; we = w; wdata = d; re = r;
      @(negedge clk);
      we = 4'h0; re = 1'b0;
   endtask

   task automatic sb_pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check(e.name, rdata, e.val);
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      sb_q.push_back('{name, exp});
      bus_cycle(a, 4'h0, 32'h0, 1'b1);
      sb_pop_check();
   endtask

   task automatic rd_val(input logic [31:0] a, output logic [31:0] v);
      bus_cycle(a, 4'h0, 32'h0, 1'b1);
      v = rdata;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_cycle(a, 4'hF, d, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop;
      idle(CPB);
      rx = 1'b1;
   endtask

   initial begin
      vec_t        tbl[12];
      logic        tx_s[100];
      logic [7:0]  tx_byte;
      logic [9:0]  got, want;
      logic        seen_low;
      logic [31:0] v1, v2;

      tbl[0]  = '{"status_idle",      32'h8000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[1]  = '{"low_space_read",   32'h0000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[2]  = '{"rxdata_empty",     32'h8000_0004, 4'h0, 32'h0,  1'b1, 32'h0};
      tbl[3]  = '{"status_again",     32'h8000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[4]  = '{"unmapped_0c",      32'h8000_000C, 4'h0, 32'h0,  1'b1, 32'h0};
      tbl[5]  = '{"status_third",     32'h8000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[6]  = '{"low_space_write",  32'h0000_0008, 4'hF, 32'h41, 1'b0, 32'h1};
      tbl[7]  = '{"ready_after_low",  32'h8000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[8]  = '{"tx_write_no_we0",  32'h8000_0008, 4'h2, 32'h41, 1'b0, 32'h1};
      tbl[9]  = '{"ready_after_we1",  32'h8000_0000, 4'h0, 32'h0,  1'b1, 32'h1};
      tbl[10] = '{"unmapped_14",      32'h8000_0014, 4'h0, 32'h0,  1'b1, 32'h0};
      tbl[11] = '{"unmapped_08_read", 32'h8000_0008, 4'h0, 32'h0,  1'b1, 32'h0};

      rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 4'h0; re = 1'b0; rx = 1'b1;
      idle(3);
      check("reset_rdata", rdata, 32'h0);
      check("reset_tx", tx, 32'h1);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         sb_q.push_back('{tbl[i].name, tbl[i].exp});
         bus_cycle(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].r);
         sb_pop_check();
      end
      check("tx_idle_high", tx, 32'h1);

      // TX frame 0x55 with a status read and a second (dropped) write mid-frame.
      tx_byte = 8'h55;
      wr(32'h8000_0008, {24'h0, tx_byte});
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               tx_s[i] = tx;
               @(negedge clk);
            end
         end
         begin
            idle(20);
            rd(32'h8000_0000, 32'h0, "status_tx_busy");
            wr(32'h8000_0008, 32'hFF);
         end
      join
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 10; j++) got[j] = tx_s[k * 10 + j];
         if (k == 0)      want = 10'h000;
         else if (k == 9) want = 10'h3FF;
         else             want = {10{tx_byte[k - 1]}};
         check($sformatf("tx_bit%0d", k), {22'h0, got}, {22'h0, want});
      end
      seen_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx !== 1'b1) seen_low = 1'b1;
         @(negedge clk);
      end
      check("tx_no_second_frame", seen_low, 32'h0);
      rd(32'h8000_0000, 32'h1, "status_tx_done");

      // RX single byte.
      send_byte(8'hA3, 1'b1);
      idle(5);
      rd(32'h8000_0000, 32'h3, "status_rx_valid");
      rd(32'h8000_0004, 32'hA3, "rxdata_a3");
      rd(32'h8000_0000, 32'h1, "status_rx_cleared");

      // Overrun.
      send_byte(8'h11, 1'b1);
      idle(5);
      send_byte(8'h22, 1'b1);
      idle(5);
      rd(32'h8000_0000, 32'h7, "status_overrun");
      rd(32'h8000_0004, 32'h22, "rxdata_overrun");
      rd(32'h8000_0000, 32'h1, "status_overrun_cleared");

      // Short glitch, then a good frame to prove the FSM recovered.
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(20);
      rd(32'h8000_0000, 32'h1, "status_after_glitch");
      send_byte(8'h5A, 1'b1);
      idle(5);
      rd(32'h8000_0000, 32'h3, "status_after_recover");
      rd(32'h8000_0004, 32'h5A, "rxdata_5a");

      // Framing error.
      send_byte(8'h3C, 1'b0);
      idle(20);
      rd(32'h8000_0000, 32'h1, "status_framing_err");

      // Cycle counter.
      rd_val(32'h8000_0010, v1);
      idle(4);
      rd_val(32'h8000_0010, v2);
      check("cycle_delta", v2 - v1, 32'd5);
      check("cycle_running", (v1 != 32'h0) ? 32'h1 : 32'h0, 32'h1);
      wr(32'h8000_0018, 32'h0);
      rd(32'h8000_0010, 32'h0, "cycle_after_clear");
      rd(32'h8000_0010, 32'h1, "cycle_after_clear_plus1");

      // Reset in the middle of a TX frame with an unread RX byte pending.
      send_byte(8'h77, 1'b1);
      idle(5);
      wr(32'h8000_0008, 32'h00);
      idle(15);
      check("tx_low_before_rst", tx, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("tx_high_after_rst", tx, 32'h1);
      check("rdata_after_rst", rdata, 32'h0);
      rst = 1'b0;
      rd(32'h8000_0010, 32'h0, "cycle_after_rst");
      rd(32'h8000_0000, 32'h1, "status_after_rst");
      rd(32'h8000_0004, 32'h0, "rxdata_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
